// File: rtl/prbs_pkg.sv
// prbs_pkg: LFSR step, tap mask and checker state encoding shared by the prbs generator and checker
package prbs_pkg;

    localparam int PRBS_N = 14;
    localparam logic [PRBS_N-1:0] TAPS = 14'h3802;

    typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} prbs_chk_state_t;

    function automatic logic [PRBS_N-1:0] lfsr_step(input logic [PRBS_N-1:0] s);
        return {s[PRBS_N-2:0], ^(s & TAPS)};
    endfunction

endpackage

// File: rtl/popcount.sv
// popcount: combinational count of set bits in a W-bit word
module popcount #(
    parameter int W = 14
) (
    input  logic [W-1:0]             data,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++)
            count = count + CW'(data[i]);
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS word checker with lock detection and saturating error counters
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N          = PRBS_N,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] bit_err_count
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    localparam int CW = $clog2(N + 1);
    localparam int SW = ERR_W + 1;

    prbs_chk_state_t  state;
    logic [N-1:0]     ref_word;
    logic [N-1:0]     exp_word;
    logic             prev_valid;
    logic [MW-1:0]    match_cnt;
    logic [UW-1:0]    miss_cnt;
    logic [CW-1:0]    diff_bits;
    logic             seq_ok;
    logic             miss;
    logic             err_beat;
    logic [SW-1:0]    bit_sum;
    logic [ERR_W-1:0] err_next;
    logic [ERR_W-1:0] bit_next;

    assign exp_word = lfsr_step(ref_word);

    popcount #(.W(N)) u_pop (
        .data  (in_data ^ exp_word),
        .count (diff_bits)
    );

    // all-zero is the LFSR lock-up state, so it never counts as a sequence match
    always_comb begin
        miss     = in_data != exp_word;
        seq_ok   = !miss && in_data != '0;
        err_beat = in_valid && state == LOCKED && miss;
        bit_sum  = {1'b0, bit_err_count} + SW'(diff_bits);
        err_next = &err_count ? err_count : err_count + ERR_W'(1);
        bit_next = bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SEARCH;
            ref_word      <= '0;
            prev_valid    <= 1'b0;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            locked        <= 1'b0;
            err_pulse     <= 1'b0;
            err_count     <= '0;
            bit_err_count <= '0;
        end else begin
            err_pulse <= err_beat;
            if (clear) begin
                err_count     <= '0;
                bit_err_count <= '0;
            end else if (err_beat) begin
                err_count     <= err_next;
                bit_err_count <= bit_next;
            end
            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        ref_word   <= in_data;
                        prev_valid <= 1'b1;
                        if (prev_valid && seq_ok) begin
                            state     <= SYNC;
                            match_cnt <= MW'(1);
                        end
                    end
                    SYNC: begin
                        ref_word <= in_data;
                        if (!seq_ok) begin
                            state     <= SEARCH;
                            match_cnt <= '0;
                        end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else begin
                            match_cnt <= match_cnt + MW'(1);
                        end
                    end
                    LOCKED: begin
                        // free-running reference: a corrupted word cannot derail the prediction
                        ref_word <= exp_word;
                        if (!miss) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == UW'(UNLOCK_CNT - 1)) begin
                            state      <= SEARCH;
                            locked     <= 1'b0;
                            prev_valid <= 1'b0;
                            miss_cnt   <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + UW'(1);
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule
